// File: rtl/de_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : de_scoreboard                                                 |
// | Purpose  : Decode-stage register scoreboard with per-register pending    |
// |            counters, RAW hazard detection and writeback bypass.          |
// | Options  : SB_WAW_STALL_EN - limit each register to one writer in flight |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module de_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int NSRC      = 2,
  parameter int NWB       = 1,
  parameter int CNTBITS   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC-1:0]           src_use,
  input  logic [NSRC*REGNOBITS-1:0] src_regno,
  input  logic                      issue_valid,
  input  logic                      issue_wr_reg,
  input  logic [REGNOBITS-1:0]      issue_rd,
  input  logic                      ext_stall,
  input  logic [NWB-1:0]            wb_valid,
  input  logic [NWB*REGNOBITS-1:0]  wb_regno,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [NREGS-1:0]          pending,
  output logic                      err
);

  localparam int c_HITBITS = $clog2(NWB + 1);
  localparam int c_SUMBITS = ((CNTBITS > c_HITBITS) ? CNTBITS : c_HITBITS) + 1;
  localparam logic [CNTBITS-1:0] c_CNT_MAX = '1;

  logic [CNTBITS-1:0] r_cnt     [NREGS];
  logic [CNTBITS-1:0] w_cnt_nxt [NREGS];
  logic [NREGS-1:0]   r_pending;
  logic               r_err;

  // w_busy reflects the bypassed count: pending writes not retiring this cycle
  logic [NREGS-1:0]   w_busy;
  logic [NREGS-1:0]   w_full;
  logic [NREGS-1:0]   w_unf;
  logic               w_src_haz;
  logic               w_sat;
  logic               w_waw;
  logic               w_issue_wr;

  always_comb begin
    logic [REGNOBITS-1:0] v_regno;
    w_src_haz = 1'b0;
    v_regno   = '0;
    for (int i = 0; i < NSRC; i++) begin
      v_regno = src_regno[i*REGNOBITS +: REGNOBITS];
      if (src_use[i] && (v_regno != '0) && w_busy[v_regno])
        w_src_haz = 1'b1;
    end
  end

  assign w_sat = issue_wr_reg && (issue_rd != '0) && w_full[issue_rd];

`ifdef SB_WAW_STALL_EN
  assign w_waw = issue_wr_reg && (issue_rd != '0) && w_busy[issue_rd];
`else
  assign w_waw = 1'b0;
`endif

  assign stall      = issue_valid & (w_src_haz | w_sat | w_waw | ext_stall);
  assign issue_fire = issue_valid & ~stall;
  assign w_issue_wr = issue_fire & issue_wr_reg & (issue_rd != '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_busy[r]    = 1'b0;
      assign w_full[r]    = 1'b0;
      assign w_unf[r]     = 1'b0;
      assign w_cnt_nxt[r] = '0;
    end else begin : g_track
      logic [c_HITBITS-1:0] w_hits;
      logic [c_SUMBITS-1:0] w_sum;
      logic [c_SUMBITS-1:0] w_sub;

      always_comb begin
        w_hits = '0;
        for (int p = 0; p < NWB; p++) begin
          if (wb_valid[p] && (wb_regno[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)))
            w_hits = w_hits + c_HITBITS'(1);
        end
      end

      // Saturation stall keeps the increment from overflowing, so w_sum fits
      assign w_sub        = c_SUMBITS'(w_hits);
      assign w_sum        = c_SUMBITS'(r_cnt[r])
                          + c_SUMBITS'(w_issue_wr && (issue_rd == REGNOBITS'(r)));
      assign w_busy[r]    = c_SUMBITS'(r_cnt[r]) > w_sub;
      assign w_full[r]    = r_cnt[r] == c_CNT_MAX;
      assign w_unf[r]     = w_sum < w_sub;
      assign w_cnt_nxt[r] = w_unf[r] ? '0 : CNTBITS'(w_sum - w_sub);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++)
        r_cnt[r] <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r]     <= w_cnt_nxt[r];
        r_pending[r] <= |w_cnt_nxt[r];
      end
      r_err <= r_err | (|w_unf);
    end
  end

  assign pending = r_pending;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_de_scoreboard.sv
`default_nettype none
// Directed table-driven bench for de_scoreboard (NWB=2, other parameters default).
module tb_de_scoreboard;

  logic        clk;
  logic        reset;
  logic [1:0]  src_use;
  logic [9:0]  src_regno;
  logic        issue_valid;
  logic        issue_wr_reg;
  logic [4:0]  issue_rd;
  logic        ext_stall;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_regno;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  de_scoreboard #(
    .NREGS(32), .REGNOBITS(5), .NSRC(2), .NWB(2), .CNTBITS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .src_use(src_use), .src_regno(src_regno),
    .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .ext_stall(ext_stall),
    .wb_valid(wb_valid), .wb_regno(wb_regno),
    .stall(stall), .issue_fire(issue_fire), .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic        wr;
    logic [4:0]  rd;
    logic [1:0]  su;
    logic [4:0]  s1;
    logic [4:0]  s0;
    logic        ext;
    logic [1:0]  wv;
    logic [4:0]  w1;
    logic [4:0]  w0;
    logic        e_stall;
    logic        e_fire;
    logic [31:0] e_pend;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(int rst_n, int iv, int wr, int rd, int su, int s1, int s0,
                              int ext, int wv, int w1, int w0,
                              int es, int ef, int unsigned ep, int ee);
    vec_t v;
    v.rst_n = 1'(rst_n); v.iv = 1'(iv); v.wr = 1'(wr); v.rd = 5'(rd);
    v.su = 2'(su); v.s1 = 5'(s1); v.s0 = 5'(s0); v.ext = 1'(ext);
    v.wv = 2'(wv); v.w1 = 5'(w1); v.w0 = 5'(w0);
    v.e_stall = 1'(es); v.e_fire = 1'(ef); v.e_pend = 32'(ep); v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic chk(input string what, input string tag, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, what, act, exp);
    end
  endtask

  // Drive one cycle at negedge, check combinational and registered outputs 1ns later
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    reset        = v.rst_n;
    issue_valid  = v.iv;
    issue_wr_reg = v.wr;
    issue_rd     = v.rd;
    src_use      = v.su;
    src_regno    = {v.s1, v.s0};
    ext_stall    = v.ext;
    wb_valid     = v.wv;
    wb_regno     = {v.w1, v.w0};
    #1;
    chk("stall",      tag, idx, 32'(stall),      32'(v.e_stall));
    chk("issue_fire", tag, idx, 32'(issue_fire), 32'(v.e_fire));
    chk("pending",    tag, idx, pending,         v.e_pend);
    chk("err",        tag, idx, 32'(err),        32'(v.e_err));
  endtask

  vec_t base_q[$];
  vec_t seq_q[$];
  vec_t unf_q[$];

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_wr_reg = 1'b0; issue_rd = '0;
    src_use = '0; src_regno = '0; ext_stall = 1'b0; wb_valid = '0; wb_regno = '0;

    //                rst iv wr rd su s1 s0 ex wv w1 w0   st fi pend   er
    base_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0,     0));
    base_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(1, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0,  1, 0, 'h20,  0));
    base_q.push_back(mk(1, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0,  1, 0, 'h20,  0));
    base_q.push_back(mk(1, 1, 0, 0, 1, 0, 5, 0, 1, 0, 5,  0, 1, 'h20,  0));
    base_q.push_back(mk(1, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
    base_q.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    base_q.push_back(mk(1, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0,  0, 1, 'h8,   0));
    base_q.push_back(mk(1, 1, 0, 0, 2, 3, 0, 0, 0, 0, 0,  1, 0, 'h8,   0));
    base_q.push_back(mk(1, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0,  0, 0, 'h8,   0));
    base_q.push_back(mk(1, 1, 0, 0, 2, 3, 0, 0, 2, 3, 0,  0, 1, 'h8,   0));
    base_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
    base_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0,     0));
    base_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0,  0, 0, 0,     0));
    base_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));

`ifdef SB_WAW_STALL_EN
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 1, 0, 7,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h80,  0));
    seq_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7,  0, 0, 'h80,  0));
    seq_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
`else
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 1, 0, 7,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h80,  0));
    seq_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 7, 7,  0, 0, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h80,  0));
    seq_q.push_back(mk(1, 1, 0, 0, 1, 0, 7, 0, 3, 7, 7,  1, 0, 'h80,  0));
    seq_q.push_back(mk(1, 1, 0, 0, 1, 0, 7, 0, 1, 0, 7,  0, 1, 'h80,  0));
    seq_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
`endif

    unf_q.push_back(mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 9, 9,  0, 0, 'h200, 0));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     1));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     1));
    unf_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
    unf_q.push_back(mk(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,     0));
    unf_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     0));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4,  0, 0, 0,     0));
    unf_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,     1));
    unf_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0,     0));

    for (int i = 0; i < base_q.size(); i++) apply(base_q[i], "base", i);
    for (int i = 0; i < seq_q.size();  i++) apply(seq_q[i],  "multi", i);
    for (int i = 0; i < unf_q.size();  i++) apply(unf_q[i],  "unf", i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
